// File: rtl/pipelined_mux_nto1.sv
// N-to-1 data selector feeding a two-entry (head + skid) valid/ready pipeline stage.
// Selection is combinational in the accept cycle; both entries are registered.
module pipelined_mux_nto1 #(
  parameter int NBits   = 32,
  parameter int NInputs = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [$clog2(NInputs)-1:0] in_Selector,
  input  logic [NInputs*NBits-1:0]  MUX_Data_dw,
  input  logic                      MUX_InValid,
  output logic                      MUX_InReady,
  output logic [NBits-1:0]          MUX_Output_dw,
  output logic                      MUX_OutValid,
  input  logic                      MUX_OutReady,
  output logic [1:0]                out_Count,
  output logic                      out_SelError
);

  localparam int SelBits = $clog2(NInputs);
  localparam logic [SelBits:0] NumInputs = (SelBits + 1)'(NInputs);

  logic             head_valid, skid_valid, in_ready_q, sel_err_q;
  logic [NBits-1:0] head_data, skid_data;
  logic [NBits-1:0] sel_data;
  logic             sel_oob, accept, consume;
  logic             head_valid_n, skid_valid_n;
  logic [NBits-1:0] head_data_n, skid_data_n;

  assign sel_oob = ({1'b0, in_Selector} >= NumInputs);
  assign accept  = MUX_InValid & in_ready_q & ~flush;
  assign consume = head_valid & MUX_OutReady;

  // Out-of-range selectors never match a loop index and fall back to input 0.
  always_comb begin
    sel_data = MUX_Data_dw[NBits-1:0];
    for (int unsigned k = 1; k < NInputs; k++) begin
      if (in_Selector == SelBits'(k)) sel_data = MUX_Data_dw[k*NBits +: NBits];
    end
  end

  always_comb begin
    head_valid_n = head_valid;
    skid_valid_n = skid_valid;
    head_data_n  = head_data;
    skid_data_n  = skid_data;
    if (consume && skid_valid) begin
      head_data_n  = skid_data;
      skid_valid_n = 1'b0;
    end else if (consume) begin
      head_valid_n = accept;
      if (accept) head_data_n = sel_data;
    end else if (accept) begin
      if (head_valid) begin
        skid_valid_n = 1'b1;
        skid_data_n  = sel_data;
      end else begin
        head_valid_n = 1'b1;
        head_data_n  = sel_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      head_data  <= '0;
      skid_data  <= '0;
      in_ready_q <= 1'b1;
      sel_err_q  <= 1'b0;
    end else if (flush) begin
      // Data registers keep their contents; only occupancy is discarded.
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      head_valid <= head_valid_n;
      skid_valid <= skid_valid_n;
      head_data  <= head_data_n;
      skid_data  <= skid_data_n;
      in_ready_q <= ~skid_valid_n;
      if (accept && sel_oob) sel_err_q <= 1'b1;
    end
  end

  assign MUX_InReady   = in_ready_q;
  assign MUX_Output_dw = head_data;
  assign MUX_OutValid  = head_valid;
  assign out_Count     = {1'b0, head_valid} + {1'b0, skid_valid};
  assign out_SelError  = sel_err_q;

endmodule
